// File: rtl/afe_frame_aligner.sv
// Multi-lane LVDS ADC word aligner. It bitslips the ISERDES until the frame lane reads
// FRAME_PATTERN, qualifies the lock, and then forwards aligned words from every channel.
module afe_frame_aligner #(
  parameter int                NUM_CH        = 8,
  parameter int                WORD_W        = 14,
  parameter logic [WORD_W-1:0] FRAME_PATTERN = 14'h3F80,
  parameter int                SLIP_WAIT     = 8,
  parameter int                LOCK_COUNT    = 16,
  parameter int                ERR_LIMIT     = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     align_start,
  input  logic                     frame_valid,
  input  logic [WORD_W-1:0]        frame_word,
  input  logic [NUM_CH*WORD_W-1:0] data_in,
  output logic                     bitslip,
  output logic [NUM_CH*WORD_W-1:0] data_out,
  output logic                     data_valid,
  output logic                     locked,
  output logic                     align_fail,
  output logic                     lock_lost,
  output logic [4:0]               slip_count
);

  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int ERR_W   = $clog2(ERR_LIMIT + 1);

  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [ERR_W-1:0]   ERR_LAST   = ERR_W'(ERR_LIMIT - 1);
  localparam logic [4:0]         SLIP_LAST  = 5'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_SLIP,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t                     state_q, state_d;
  logic [WAIT_W-1:0]          wait_cnt_q, wait_cnt_d;
  logic [MATCH_W-1:0]         match_cnt_q, match_cnt_d;
  logic [ERR_W-1:0]           err_cnt_q, err_cnt_d;
  logic [4:0]                 slip_count_q, slip_count_d;
  logic                       bitslip_q, bitslip_d;
  logic                       locked_q, locked_d;
  logic                       align_fail_q, align_fail_d;
  logic                       lock_lost_q, lock_lost_d;
  logic                       data_valid_q, data_valid_d;
  logic [NUM_CH*WORD_W-1:0]   data_out_q, data_out_d;
  logic                       frame_match;

  assign frame_match = (frame_word == FRAME_PATTERN);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    match_cnt_d  = match_cnt_q;
    err_cnt_d    = err_cnt_q;
    slip_count_d = slip_count_q;
    bitslip_d    = 1'b0;
    locked_d     = locked_q;
    align_fail_d = align_fail_q;
    lock_lost_d  = lock_lost_q;
    data_valid_d = 1'b0;
    data_out_d   = data_out_q;

    unique case (state_q)
      S_IDLE: ;

      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d     = S_CHECK;
          wait_cnt_d  = '0;
          match_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      // The lock test comes first; a mismatch throws away any partial run of matches.
      S_CHECK: begin
        if (frame_valid) begin
          if (frame_match) begin
            if (match_cnt_q == MATCH_LAST) begin
              state_d     = S_LOCKED;
              locked_d    = 1'b1;
              err_cnt_d   = '0;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            match_cnt_d = '0;
            if (slip_count_q == SLIP_LAST) begin
              state_d      = S_FAIL;
              align_fail_d = 1'b1;
            end else begin
              state_d      = S_SLIP;
              bitslip_d    = 1'b1;
              slip_count_d = slip_count_q + 5'd1;
            end
          end
        end
      end

      S_SLIP: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end

      // The word that completes the error run is not forwarded, so data_valid never rises with locked low.
      S_LOCKED: begin
        if (frame_valid) begin
          if (!frame_match && err_cnt_q == ERR_LAST) begin
            state_d      = S_WAIT;
            locked_d     = 1'b0;
            lock_lost_d  = 1'b1;
            slip_count_d = '0;
            wait_cnt_d   = '0;
            err_cnt_d    = '0;
          end else begin
            data_out_d   = data_in;
            data_valid_d = 1'b1;
            err_cnt_d    = frame_match ? '0 : err_cnt_q + 1'b1;
          end
        end
      end

      S_FAIL: ;

      default: state_d = S_IDLE;
    endcase

    if (align_start) begin
      state_d      = S_WAIT;
      wait_cnt_d   = '0;
      match_cnt_d  = '0;
      err_cnt_d    = '0;
      slip_count_d = '0;
      bitslip_d    = 1'b0;
      locked_d     = 1'b0;
      align_fail_d = 1'b0;
      lock_lost_d  = 1'b0;
      data_valid_d = 1'b0;
      data_out_d   = data_out_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      match_cnt_q  <= '0;
      err_cnt_q    <= '0;
      slip_count_q <= '0;
      bitslip_q    <= 1'b0;
      locked_q     <= 1'b0;
      align_fail_q <= 1'b0;
      lock_lost_q  <= 1'b0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      match_cnt_q  <= match_cnt_d;
      err_cnt_q    <= err_cnt_d;
      slip_count_q <= slip_count_d;
      bitslip_q    <= bitslip_d;
      locked_q     <= locked_d;
      align_fail_q <= align_fail_d;
      lock_lost_q  <= lock_lost_d;
      data_valid_q <= data_valid_d;
      data_out_q   <= data_out_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign locked     = locked_q;
  assign align_fail = align_fail_q;
  assign lock_lost  = lock_lost_q;
  assign slip_count = slip_count_q;

endmodule
